// File: rtl/i2c_target_regs_if.sv
// Pin-level I2C target bus plus the simple register port it feeds.
interface i2c_target_regs_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;

  modport master (output scl_i, sda_i, rd_data,
                  input  sda_oe, wr_stb, wr_addr, wr_data, rd_addr, busy);
  modport slave  (input  scl_i, sda_i, rd_data,
                  output sda_oe, wr_stb, wr_addr, wr_data, rd_addr, busy);
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target emulating a pointer-addressed register map: address match,
// register pointer, streaming writes out / reads in over a register port.
module i2c_in_filter #(
  parameter int GLITCH_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0]            sync;
  logic [GLITCH_CYC-1:0] hist;

  // Idle bus is high, so everything resets to 1 to avoid a phantom START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
      hist <= '1;
      q    <= 1'b1;
    end else begin
      sync <= {sync[0], d};
      hist <= (hist << 1) | GLITCH_CYC'(sync[1]);
      if (&hist)       q <= 1'b1;
      else if (~|hist) q <= 1'b0;
    end
  end
endmodule

module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR   = 7'h10,
  parameter int         GLITCH_CYC = 2
) (
  input logic              clk,
  input logic              rst_n,
  i2c_target_regs_if.slave bus
);
  typedef enum logic [3:0] {IDLE, ADDR, ACK_A, PTR, ACK_P, WDATA, ACK_W, RDATA, MACK} state_t;

  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] sh_q, sh_d, ptr_q, ptr_d;
  logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic       sda_oe_q, sda_oe_d, busy_q, busy_d, wr_stb_q, wr_stb_d;
  logic       rw_q, rw_d, nack_q, nack_d;

  logic [1:0] raw, filt, filt_q;
  logic       scl_f, sda_f, scl_rise, scl_fall, start, stop;
  logic [7:0] byte_in;

  assign raw = {bus.scl_i, bus.sda_i};
  for (genvar i = 0; i < 2; i++) begin : g_filt
    i2c_in_filter #(.GLITCH_CYC(GLITCH_CYC)) u_filt (
      .clk(clk), .rst_n(rst_n), .d(raw[i]), .q(filt[i]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) filt_q <= '1;
    else        filt_q <= filt;
  end

  assign scl_f    = filt[1];
  assign sda_f    = filt[0];
  assign scl_rise = scl_f & ~filt_q[1];
  assign scl_fall = ~scl_f & filt_q[1];
  assign start    = scl_f & filt_q[1] & filt_q[0] & ~sda_f;
  assign stop     = scl_f & filt_q[1] & ~filt_q[0] & sda_f;
  assign byte_in  = {sh_q[6:0], sda_f};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      sh_q      <= '0;
      ptr_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      rw_q      <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      sh_q      <= sh_d;
      ptr_q     <= ptr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      rw_q      <= rw_d;
      nack_q    <= nack_d;
    end
  end

  // bitcnt 8 in an ACK state means "8th fall pending", 9 means "ACK driven".
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    rw_d      = rw_q;
    nack_d    = nack_q;
    if (start) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else if (stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sh_d     = byte_in;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            if (byte_in[7:1] == DEV_ADDR) begin
              state_d = ACK_A;
              rw_d    = byte_in[0];
              busy_d  = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        PTR, WDATA: if (scl_rise) begin
          sh_d     = byte_in;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            if (state_q == PTR) begin
              ptr_d   = byte_in;
              state_d = ACK_P;
            end else begin
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = byte_in;
              ptr_d     = ptr_q + 8'd1;
              state_d   = ACK_W;
            end
          end
        end
        ACK_A, ACK_P, ACK_W: if (scl_fall) begin
          if (bitcnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            bitcnt_d = 4'd9;
          end else begin
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
            if (state_q != ACK_A) state_d = WDATA;
            else if (!rw_q)       state_d = PTR;
            else begin
              state_d  = RDATA;
              sh_d     = bus.rd_data;
              sda_oe_d = ~bus.rd_data[7];
            end
          end
        end
        RDATA: begin
          if (scl_rise) bitcnt_d = bitcnt_q + 4'd1;
          else if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 8'd1;
              state_d  = MACK;
            end else begin
              sh_d     = sh_q << 1;
              sda_oe_d = ~sh_q[6];
            end
          end
        end
        MACK: begin
          if (scl_rise) nack_d = sda_f;
          else if (scl_fall) begin
            if (nack_q) state_d = IDLE;
            else begin
              state_d  = RDATA;
              bitcnt_d = '0;
              sh_d     = bus.rd_data;
              sda_oe_d = ~bus.rd_data[7];
            end
          end
        end
        IDLE:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.sda_oe  = sda_oe_q;
  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_addr = ptr_q;
  assign bus.busy    = busy_q;
endmodule
